sha256_msg_padder: RTL
======================

Name: sha256_msg_padder

Overview:
- Upstream of the message scheduler.
- Accepts the raw message as a 32-bit big-endian word stream and applies SHA-256 padding: the 0x80 byte, zero fill, and the 64-bit bit length.
- Writes each 512-bit block into the scheduler's W memory, one word per cycle at addresses 0–15.
- After each block it raises block_valid and holds off until the controller acknowledges the block.

Parameters:
- LEN_W, 64, width of the internal bit-length counter. Fixed at 64 by SHA-256; the counter wraps mod 2^64.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  input word valid
- in_ready  out  1  padder accepts a word this cycle
- in_data  in  32  message word, first byte in bits [31:24]
- in_last  in  1  final word of the message
- in_nbytes  in  3  valid bytes in a last word, 0..4. Ignored when in_last=0 (treated as 4). Values 5..7 are treated as 4.
- message_word_out  out  32  word to the scheduler W memory
- message_word_addr  out  4  target address, 0..15
- write_enable_out  out  1  write strobe, one cycle per word
- block_valid  out  1  16 words written, block ready for compression
- block_last  out  1  qualifies block_valid: final block of the message
- block_ack  in  1  controller has consumed the block (one-cycle pulse)

Behaviour:
- Reset values: in_ready=0, message_word_out=0, message_word_addr=0, write_enable_out=0, block_valid=0, block_last=0. Bit-length counter=0, word index=0, state=LOAD.
- All outputs are registered except in_ready, which is (state==LOAD).
- A handshake occurs when in_valid && in_ready. The resulting write appears on the next clock edge (latency 1).
- Word index idx increments on every write and wraps 15->0.
- The bit counter adds 32 per non-last word and 8*nbytes on the last word.

States:
- LOAD
  - Non-last word: write in_data at idx.
  - Last word, nbytes<4: write the kept bytes, with byte[nbytes]=0x80 and lower bytes zero. Mask off stale input bytes (data is masked, not passed through). Then go to ZERO, or go to FILL if idx was 14 or 15.
  - Last word, nbytes=4: write in_data, then go to PAD80.
  - Whenever idx=15 is written, enter WAIT_ACK with a resume target.
- PAD80: write 0x80000000, then go to ZERO, or to FILL if this write was at idx 14 or 15.
- ZERO: write 0 until idx=13 has been written, then go to LEN_HI.
- FILL: write 0 through idx 15, then WAIT_ACK with block_last=0 and resume target ZERO.
- LEN_HI: write length[63:32] at idx 14.
- LEN_LO: write length[31:0] at idx 15. Then WAIT_ACK with block_last=1 and resume target LOAD.

WAIT_ACK:
- block_valid=1 from the cycle after the idx-15 write, held until block_ack is sampled high.
- On ack: block_valid=0 and block_last=0 next cycle, then go to the resume target.
- After a final block: clear the bit counter and set idx=0.
- Resume targets: LOAD, ZERO, or PAD80. PAD80 is the target when the 64-byte-aligned last word filled idx 15.
- block_ack outside WAIT_ACK is ignored.

Boundary conditions:
- in_last with nbytes=0 emits 0x80000000 at the current idx. This covers the empty message.
- Zero fill resumes only when the 0x80 word landed at idx ≤13; otherwise padding spills into an extra block.
- Reset mid-block aborts immediately, returns to LOAD with all state cleared, and produces no partial block_valid.
- in_data and in_last are ignored while in_ready=0.

Test Plan:
1. "abc": one word 0x61626300, in_last=1, nbytes=3
   -> addr0=0x61626380, addr1..14=0, addr15=0x00000018.
   -> block_valid=1 and block_last=1 one cycle after the addr15 write.
2. Empty message: in_last=1, nbytes=0
   -> addr0=0x80000000, addr1..15=0.
   -> block_last=1.
3. 56-byte message: 14 words, last has nbytes=4
   -> block1: addr14=0x80000000, addr15=0, block_last=0.
   -> After ack, block2: addr0..13=0, addr14=0, addr15=0x000001C0, block_last=1.
4. 64-byte message: 16 words
   -> block1 is all data, block_last=0.
   -> After ack, block2: addr0=0x80000000, addr15=0x00000200, block_last=1.
5. Backpressure: hold in_valid=1 during WAIT_ACK, delay block_ack 10 cycles
   -> in_ready=0 and no write_enable_out during the wait.
   -> The first word of the next message is written the cycle after acceptance, following the ack.
6. Reset mid-block: assert reset_n=0 after 7 writes
   -> all outputs 0 immediately.
   -> After release, "abc" again produces exactly the scenario 1 result.

Source files
------------

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: turns a 32-bit big-endian word stream into padded
// 512-bit blocks written one word per cycle into the scheduler's W memory.
module sha256_msg_padder #(
    parameter int LEN_W = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_last,
    input  logic [2:0]  in_nbytes,
    output logic [31:0] message_word_out,
    output logic [3:0]  message_word_addr,
    output logic        write_enable_out,
    output logic        block_valid,
    output logic        block_last,
    input  logic        block_ack
);

    typedef enum logic [2:0] {
        S_LOAD,
        S_PAD80,
        S_ZERO,
        S_FILL,
        S_LEN_HI,
        S_LEN_LO,
        S_WAIT_ACK
    } state_e;

    state_e            state_q, state_d;
    state_e            resume_q, resume_d;
    state_e            pad_state;
    logic [3:0]        idx_q, idx_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [31:0]       word_q, word_d;
    logic [3:0]        addr_q, addr_d;
    logic              we_q, we_d;
    logic              bv_q, bv_d;
    logic              bl_q, bl_d;
    logic              final_q, final_d;
    logic              ready_q;

    logic              wr;
    logic [31:0]       wr_data;
    logic [2:0]        eff_nb;
    logic [31:0]       masked;

    // ready_q keeps in_ready low while reset is held and rises on the first edge after.
    assign in_ready          = ready_q && (state_q == S_LOAD);
    assign message_word_out  = word_q;
    assign message_word_addr = addr_q;
    assign write_enable_out  = we_q;
    assign block_valid       = bv_q;
    assign block_last        = bl_q;

    // NOTE: every signal assigned in an always_comb gets a default first, so no
    // path through the case statements can leave it unassigned and infer a latch.
    always_comb begin
        eff_nb = 3'd4;
        if (in_last && (in_nbytes < 3'd4)) begin
            eff_nb = in_nbytes;
        end
        masked = in_data;
        unique case (eff_nb)
            3'd0:    masked = 32'h8000_0000;
            3'd1:    masked = {in_data[31:24], 24'h80_0000};
            3'd2:    masked = {in_data[31:16], 16'h8000};
            3'd3:    masked = {in_data[31:8], 8'h80};
            default: masked = in_data;
        endcase
    end

    // Where to go after the word carrying the 0x80 marker lands at idx_q.
    always_comb begin
        pad_state = S_ZERO;
        if (idx_q == 4'd15) begin
            pad_state = S_WAIT_ACK;
        end else if (idx_q == 4'd14) begin
            pad_state = S_FILL;
        end else if (idx_q == 4'd13) begin
            pad_state = S_LEN_HI;
        end
    end

    always_comb begin
        state_d  = state_q;
        resume_d = resume_q;
        idx_d    = idx_q;
        len_d    = len_q;
        word_d   = word_q;
        addr_d   = addr_q;
        we_d     = 1'b0;
        bv_d     = bv_q;
        bl_d     = bl_q;
        final_d  = final_q;
        wr       = 1'b0;
        wr_data  = 32'h0;

        unique case (state_q)
            S_LOAD: begin
                if (in_valid && in_ready) begin
                    wr      = 1'b1;
                    len_d   = len_q + LEN_W'({eff_nb, 3'b000});
                    final_d = 1'b0;
                    if (!in_last) begin
                        wr_data = in_data;
                        if (idx_q == 4'd15) begin
                            state_d  = S_WAIT_ACK;
                            resume_d = S_LOAD;
                        end
                    end else if (eff_nb == 3'd4) begin
                        wr_data  = in_data;
                        state_d  = (idx_q == 4'd15) ? S_WAIT_ACK : S_PAD80;
                        resume_d = S_PAD80;
                    end else begin
                        wr_data  = masked;
                        state_d  = pad_state;
                        resume_d = S_ZERO;
                    end
                end
            end
            S_PAD80: begin
                wr       = 1'b1;
                wr_data  = 32'h8000_0000;
                state_d  = pad_state;
                resume_d = S_ZERO;
                final_d  = 1'b0;
            end
            S_ZERO: begin
                wr = 1'b1;
                if (idx_q == 4'd13) begin
                    state_d = S_LEN_HI;
                end
            end
            S_FILL: begin
                wr = 1'b1;
                if (idx_q == 4'd15) begin
                    state_d  = S_WAIT_ACK;
                    resume_d = S_ZERO;
                    final_d  = 1'b0;
                end
            end
            S_LEN_HI: begin
                wr      = 1'b1;
                wr_data = len_q[63:32];
                state_d = S_LEN_LO;
            end
            S_LEN_LO: begin
                wr       = 1'b1;
                wr_data  = len_q[31:0];
                state_d  = S_WAIT_ACK;
                resume_d = S_LOAD;
                final_d  = 1'b1;
            end
            S_WAIT_ACK: begin
                // An ack only counts once block_valid is actually visible.
                if (bv_q && block_ack) begin
                    bv_d    = 1'b0;
                    bl_d    = 1'b0;
                    state_d = resume_q;
                    if (final_q) begin
                        len_d = '0;
                        idx_d = 4'd0;
                    end
                end else begin
                    bv_d = 1'b1;
                    bl_d = final_q;
                end
            end
            default: state_d = S_LOAD;
        endcase

        if (wr) begin
            word_d = wr_data;
            addr_d = idx_q;
            we_d   = 1'b1;
            idx_d  = idx_q + 4'd1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_LOAD;
            resume_q <= S_LOAD;
            idx_q    <= 4'd0;
            len_q    <= '0;
            word_q   <= 32'h0;
            addr_q   <= 4'd0;
            we_q     <= 1'b0;
            bv_q     <= 1'b0;
            bl_q     <= 1'b0;
            final_q  <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            resume_q <= resume_d;
            idx_q    <= idx_d;
            len_q    <= len_d;
            word_q   <= word_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            bv_q     <= bv_d;
            bl_q     <= bl_d;
            final_q  <= final_d;
            ready_q  <= 1'b1;
        end
    end

endmodule
